// File: rtl/ps2_mouse_receiver.sv
// PS/2 device-to-host byte receiver: synchronises the raw lines, detects clock
// falling edges and deframes start/8 data/odd parity/stop into rx_data.
module ps2_mouse_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       rx_enable,
    input  logic       timer_400us_done,
    output logic       falling_edge,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_error,
    output logic       rx_framing_error,
    output logic       rx_busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic       clk_s1_q, clk_s2_q, clk_prev_q;
    logic       data_s1_q, data_s2_q;
    logic       edge_q, bit_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    // Sync flops reset to 1 (idle bus) so releasing reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            edge_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
            edge_q     <= clk_prev_q & ~clk_s2_q;
            bit_q      <= data_s2_q;
        end
    end

    // The FSM consumes the registered edge, so result pulses land one cycle after falling_edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (!rx_enable) begin
            state_d = IDLE;
        end else if (edge_q) begin
            case (state_q)
                IDLE: begin
                    if (!bit_q) begin
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                        state_d = DATA;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {bit_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = bit_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!bit_q) begin
                        ferr_d = 1'b1;
                    end else if ((^shift_q) ^ parity_q) begin
                        rx_data_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timer_400us_done && state_q != IDLE) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            rx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign falling_edge     = edge_q;
    assign rx_data          = rx_data_q;
    assign rx_valid         = valid_q;
    assign rx_parity_error  = perr_q;
    assign rx_framing_error = ferr_q;
    assign rx_busy          = (state_q != IDLE);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Bench for ps2_mouse_receiver: directed scenarios plus randomized frames
// checked against a frame-level model of the PS/2 receive rules.
module tb_ps2_mouse_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic       rx_enable = 1'b1;
    logic       timer_400us_done = 1'b0;
    logic       falling_edge, rx_valid, rx_parity_error, rx_framing_error, rx_busy;
    logic [7:0] rx_data;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0, val_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
    int last_fe_cyc = 0, last_res_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] mdl_data = 8'h00;

    ps2_mouse_receiver dut (
        .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .rx_enable(rx_enable), .timer_400us_done(timer_400us_done),
        .falling_edge(falling_edge), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_error(rx_parity_error), .rx_framing_error(rx_framing_error),
        .rx_busy(rx_busy), .dbg_state(dbg_state)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: counts every output pulse and records received bytes.
    always @(negedge clk) begin
        if (!reset) begin
            if (falling_edge) begin fe_cnt++; last_fe_cyc = cyc; end
            if (rx_valid) begin val_cnt++; got_q.push_back(rx_data); last_res_cyc = cyc; end
            if (rx_parity_error) begin perr_cnt++; last_res_cyc = cyc; end
            if (rx_framing_error) begin ferr_cnt++; last_res_cyc = cyc; end
        end
    end

    // Frame-level rules: 0 = good byte, 1 = parity error, 2 = framing error.
    function automatic int model_outcome(logic [7:0] d, logic p, logic s);
        if (!s) return 2;
        if ((($countones(d) + int'(p)) % 2) == 1) return 0;
        return 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int half, input bit tmo);
        ps2_data_in = b;
        tick(half);
        ps2_clk_in = 1'b0;
        if (tmo) begin
            tick(3);
            timer_400us_done = 1'b1;
            tick(1);
            timer_400us_done = 1'b0;
            tick(half - 4);
        end else begin
            tick(half);
        end
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int half, input int nbits, input int tmo_bit);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], half, i == tmo_bit);
        ps2_data_in = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        int fe0;
        reset = 1'b1;
        tick(3);
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        checks++;
        if ({falling_edge, rx_valid, rx_parity_error, rx_framing_error, rx_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 00000",
                     {falling_edge, rx_valid, rx_parity_error, rx_framing_error, rx_busy});
        end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        reset = 1'b0;
        fe0 = fe_cnt;
        tick(10);
        checks++;
        if (fe_cnt - fe0 != 0) begin errors++; $display("FAIL reset_spurious_edge got %0d exp 0", fe_cnt - fe0); end
    endtask

    task automatic test_idle_edge();
        int f0;
        f0 = ferr_cnt;
        ps2_data_in = 1'b1;
        ps2_clk_in = 1'b0;
        tick(2);
        checks++;
        if (falling_edge !== 1'b0) begin errors++; $display("FAIL edge_early got %b exp 0", falling_edge); end
        tick(1);
        checks++;
        if (falling_edge !== 1'b1) begin errors++; $display("FAIL edge_latency got %b exp 1", falling_edge); end
        tick(1);
        checks++;
        if ({falling_edge, rx_framing_error, rx_busy} !== 3'b010) begin
            errors++;
            $display("FAIL idle_high_bit got fe/ferr/busy %b exp 010", {falling_edge, rx_framing_error, rx_busy});
        end
        ps2_clk_in = 1'b1;
        tick(8);
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL idle_ferr_count got %0d exp 1", ferr_cnt - f0); end
    endtask

    task automatic test_frame_fa();
        int fe0, v0, p0, f0;
        fe0 = fe_cnt; v0 = val_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'hFA, 1'b1, 1'b1, 2000, 11, -1);
        if (model_outcome(8'hFA, 1'b1, 1'b1) == 0) mdl_data = 8'hFA;
        checks++;
        if (fe_cnt - fe0 != 11) begin errors++; $display("FAIL fa_edges got %0d exp 11", fe_cnt - fe0); end
        checks++;
        if (val_cnt - v0 != 1 || perr_cnt != p0 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL fa_pulses got v%0d p%0d f%0d exp v1 p0 f0", val_cnt - v0, perr_cnt - p0, ferr_cnt - f0);
        end
        checks++;
        if (rx_data !== mdl_data) begin errors++; $display("FAIL fa_data got %h exp %h", rx_data, mdl_data); end
        checks++;
        if (last_res_cyc != last_fe_cyc + 1) begin
            errors++;
            $display("FAIL fa_result_timing got %0d exp %0d", last_res_cyc, last_fe_cyc + 1);
        end
    endtask

    task automatic test_parity_error();
        int v0, p0;
        v0 = val_cnt; p0 = perr_cnt;
        send_frame(8'h08, 1'b1, 1'b1, 20, 11, -1);
        checks++;
        if (perr_cnt - p0 != 1 || val_cnt != v0) begin
            errors++;
            $display("FAIL parity_err got p%0d v%0d exp p1 v0", perr_cnt - p0, val_cnt - v0);
        end
        checks++;
        if (rx_data !== mdl_data) begin errors++; $display("FAIL parity_data got %h exp %h", rx_data, mdl_data); end
    endtask

    task automatic test_framing();
        int v0, p0, f0;
        v0 = val_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, 1'b0, 20, 11, -1);
        checks++;
        if (ferr_cnt - f0 != 1 || perr_cnt != p0 || val_cnt != v0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL framing got f%0d p%0d v%0d st%0d exp f1 p0 v0 st0",
                     ferr_cnt - f0, perr_cnt - p0, val_cnt - v0, dbg_state);
        end
        send_frame(8'hAA, 1'b1, 1'b1, 20, 11, -1);
        mdl_data = 8'hAA;
        checks++;
        if (rx_data !== mdl_data || val_cnt - v0 != 1) begin
            errors++;
            $display("FAIL framing_recover got %h v%0d exp %h v1", rx_data, val_cnt - v0, mdl_data);
        end
    endtask

    task automatic test_timeout();
        int f0, v0;
        f0 = ferr_cnt; v0 = val_cnt;
        send_frame(8'h1F, 1'b0, 1'b1, 20, 6, -1);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got %b exp 1", rx_busy); end
        timer_400us_done = 1'b1;
        tick(1);
        timer_400us_done = 1'b0;
        checks++;
        if ({rx_framing_error, rx_busy} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_abort got ferr/busy %b exp 10", {rx_framing_error, rx_busy});
        end
        tick(1);
        checks++;
        if (ferr_cnt - f0 != 1 || rx_framing_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width got %0d exp 1", ferr_cnt - f0);
        end
        timer_400us_done = 1'b1;
        tick(1);
        timer_400us_done = 1'b0;
        tick(2);
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL timeout_idle_ignored got %0d exp 1", ferr_cnt - f0); end
        send_frame(8'hF4, 1'b0, 1'b1, 20, 11, -1);
        mdl_data = 8'hF4;
        checks++;
        if (rx_data !== mdl_data || val_cnt - v0 != 1) begin
            errors++;
            $display("FAIL timeout_recover got %h v%0d exp %h v1", rx_data, val_cnt - v0, mdl_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        send_frame(8'hFF, 1'b1, 1'b1, 20, 5, -1);
        reset = 1'b1;
        tick(1);
        checks++;
        if (rx_data !== 8'h00 || {rx_valid, rx_parity_error, rx_framing_error, rx_busy} !== 4'b0) begin
            errors++;
            $display("FAIL midreset got data %h flags %b exp 00 0000", rx_data,
                     {rx_valid, rx_parity_error, rx_framing_error, rx_busy});
        end
        tick(2);
        reset = 1'b0;
        mdl_data = 8'h00;
        v0 = val_cnt;
        tick(10);
        checks++;
        if (val_cnt != v0) begin errors++; $display("FAIL midreset_valid got %0d exp 0", val_cnt - v0); end
        send_frame(8'h55, 1'b1, 1'b1, 20, 11, -1);
        mdl_data = 8'h55;
        checks++;
        if (rx_data !== mdl_data || val_cnt - v0 != 1) begin
            errors++;
            $display("FAIL midreset_recover got %h v%0d exp %h v1", rx_data, val_cnt - v0, mdl_data);
        end
    endtask

    task automatic test_enable_and_coincide();
        int fe0, v0, p0, f0;
        send_frame(8'h33, 1'b1, 1'b1, 20, 4, -1);
        rx_enable = 1'b0;
        tick(1);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL enable_abort_busy got %b exp 0", rx_busy); end
        fe0 = fe_cnt; v0 = val_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h12, 1'b1, 1'b1, 20, 11, -1);
        checks++;
        if (fe_cnt - fe0 != 11 || val_cnt != v0 || perr_cnt != p0 || ferr_cnt != f0 || rx_data !== mdl_data) begin
            errors++;
            $display("FAIL enable_low got fe%0d v%0d p%0d f%0d data %h exp fe11 v0 p0 f0 data %h",
                     fe_cnt - fe0, val_cnt - v0, perr_cnt - p0, ferr_cnt - f0, rx_data, mdl_data);
        end
        rx_enable = 1'b1;
        tick(5);
        v0 = val_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 20, 11, 4);
        mdl_data = 8'h3C;
        checks++;
        if (rx_data !== mdl_data || val_cnt - v0 != 1 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL coincide got %h v%0d f%0d exp %h v1 f0", rx_data, val_cnt - v0, ferr_cnt - f0, mdl_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, s;
        int         half, outc, v0, p0, f0;
        exp_q.delete();
        got_q.delete();
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            half = $urandom_range(5, 30);
            outc = model_outcome(d, p, s);
            if (outc == 0) begin exp_q.push_back(d); mdl_data = d; end
            v0 = val_cnt; p0 = perr_cnt; f0 = ferr_cnt;
            send_frame(d, p, s, half, 11, -1);
            checks++;
            if (val_cnt - v0 != int'(outc == 0) || perr_cnt - p0 != int'(outc == 1) ||
                ferr_cnt - f0 != int'(outc == 2) || rx_data !== mdl_data) begin
                errors++;
                $display("FAIL random_frame d=%h p=%b s=%b got v%0d p%0d f%0d data %h exp outcome %0d data %h",
                         d, p, s, val_cnt - v0, perr_cnt - p0, ferr_cnt - f0, rx_data, outc, mdl_data);
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_byte %0d got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_idle_edge();
        test_frame_fa();
        test_parity_error();
        test_framing();
        test_timeout();
        test_reset_mid_frame();
        test_enable_and_coincide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
